// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_pkg
//   Shared encodings for the modulo up/down counter family.
//   dir_e  : direction applied on an enabled step (up_down input)
//   mode_e : behaviour at the count boundaries (sat input)
// -----------------------------------------------------------------------------
package mod_counter_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage : mod_counter_pkg

// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//   Modulo-MODULUS up/down counter with synchronous load, wrap or saturate
//   boundary handling, a one-cycle terminal-count pulse and sticky
//   overflow/underflow flags.
//
// Parameters
//   N        counter width in bits
//   MODULUS  count range 0..MODULUS-1 (2..2**N)
//   RST_VAL  value of count while in reset (0..MODULUS-1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         count enable
//   up_down    0 = up, 1 = down
//   sat        0 = wrap at the boundaries, 1 = saturate
//   load       synchronous load strobe (wins over en)
//   load_val   value loaded; clamped to MODULUS-1 when out of range
//   clr_flags  synchronous clear of ovf/unf (a same-cycle event wins)
//   count      registered count
//   tc         registered terminal-count pulse, one per boundary event
//   ovf        sticky: up-step attempted at MODULUS-1
//   unf        sticky: down-step attempted at 0
//   zero       combinational count == 0
// -----------------------------------------------------------------------------
module mod_updown_counter
    import mod_counter_pkg::*;
#(
    parameter int N       = 8,
    parameter int MODULUS = 2 ** N,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up_down,
    input  logic         sat,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         clr_flags,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         ovf,
    output logic         unf,
    output logic         zero
);

    // Parameter legality is enforced while elaborating.
    if (MODULUS < 2 || MODULUS > (2 ** N) || RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_bad_params
        $fatal(1, "mod_updown_counter: illegal parameters N=%0d MODULUS=%0d RST_VAL=%0d",
               N, MODULUS, RST_VAL);
    end

    // MODULUS itself may equal 2**N, so it is only ever held in N+1 bits.
    // The largest count value always fits in N bits.
    localparam logic [N:0]   MOD_EXT   = (N+1)'(MODULUS);
    localparam logic [N-1:0] MAX_VAL   = N'(MODULUS - 1);
    localparam logic [N-1:0] RST_COUNT = N'(RST_VAL);

    dir_e  dir;
    mode_e mode;

    assign dir  = dir_e'(up_down);
    assign mode = mode_e'(sat);

    logic         at_max;
    logic         at_zero;
    logic         up_evt;
    logic         dn_evt;
    logic [N-1:0] count_next;

    // Boundaries are detected by explicit compare, so no step ever relies
    // on N-bit arithmetic rolling over.
    assign at_max  = (count == MAX_VAL);
    assign at_zero = (count == '0);

    // Boundary detect and next-state selection. Load outranks en, and a load
    // cycle never records a boundary event.
    always_comb begin
        up_evt     = 1'b0;
        dn_evt     = 1'b0;
        count_next = count;
        if (load) begin
            if ({1'b0, load_val} < MOD_EXT) begin
                count_next = load_val;
            end else begin
                count_next = MAX_VAL;
            end
        end else if (en) begin
            if (dir == DIR_UP) begin
                if (at_max) begin
                    up_evt     = 1'b1;
                    count_next = (mode == MODE_SAT) ? count : '0;
                end else begin
                    count_next = count + N'(1);
                end
            end else begin
                if (at_zero) begin
                    dn_evt     = 1'b1;
                    count_next = (mode == MODE_SAT) ? count : MAX_VAL;
                end else begin
                    count_next = count - N'(1);
                end
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_COUNT;
        end else begin
            count <= count_next;
        end
    end

    // Flag register: tc follows every boundary event (so a saturated run
    // keeps it high), the sticky flags set on their event and otherwise
    // clear on clr_flags; a same-cycle event outranks the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc  <= 1'b0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            tc <= up_evt | dn_evt;
            if (up_evt) begin
                ovf <= 1'b1;
            end else if (clr_flags) begin
                ovf <= 1'b0;
            end
            if (dn_evt) begin
                unf <= 1'b1;
            end else if (clr_flags) begin
                unf <= 1'b0;
            end
        end
    end

    assign zero = (count == '0);

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_updown_counter
//   Directed bench for mod_updown_counter. Two instances share all inputs:
//   dut (N=4, MODULUS=10) and dut16 (N=4, MODULUS=16). Observed outputs are
//   packed as {count, tc, ovf, unf, zero} and compared against hand-computed
//   vectors one cycle at a time.
// -----------------------------------------------------------------------------
module tb_mod_updown_counter;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         en;
    logic         up_down;
    logic         sat;
    logic         load;
    logic [N-1:0] load_val;
    logic         clr_flags;

    logic [N-1:0] count;
    logic         tc;
    logic         ovf;
    logic         unf;
    logic         zero;

    logic [N-1:0] count16;
    logic         tc16;
    logic         ovf16;
    logic         unf16;
    logic         zero16;

    mod_updown_counter #(.N(N), .MODULUS(10), .RST_VAL(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up_down   (up_down),
        .sat       (sat),
        .load      (load),
        .load_val  (load_val),
        .clr_flags (clr_flags),
        .count     (count),
        .tc        (tc),
        .ovf       (ovf),
        .unf       (unf),
        .zero      (zero)
    );

    mod_updown_counter #(.N(N), .MODULUS(16), .RST_VAL(0)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up_down   (up_down),
        .sat       (sat),
        .load      (load),
        .load_val  (load_val),
        .clr_flags (clr_flags),
        .count     (count16),
        .tc        (tc16),
        .ovf       (ovf16),
        .unf       (unf16),
        .zero      (zero16)
    );

    // {count, tc, ovf, unf, zero}
    logic [7:0] obs;
    logic [7:0] obs16;
    assign obs   = {count, tc, ovf, unf, zero};
    assign obs16 = {count16, tc16, ovf16, unf16, zero16};

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_v;
    logic [7:0] exp_q[$];

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;
    localparam logic WRAP = 1'b0;
    localparam logic SAT  = 1'b1;

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic ld, input logic [N-1:0] lv, input logic e,
                          input logic ud, input logic s, input logic cl);
        load      = ld;
        load_val  = lv;
        en        = e;
        up_down   = ud;
        sat       = s;
        clr_flags = cl;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 4'd0, 1'b0, UP, WRAP, 1'b0);
        #1;
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got %h exp %h", obs, exp_v); end
        checks++;
        if (obs16 !== exp_v) begin errors++; $display("FAIL reset_state16: got %h exp %h", obs16, exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_release_hold: got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 4'd9, 1'b0, UP, WRAP, 1'b0);
        tick();
        set_in(1'b0, 4'd0, 1'b1, UP, WRAP, 1'b0);
        tick();
        exp_v = {4'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pre_reset_wrap: got %h exp %h", obs, exp_v); end
        set_in(1'b1, 4'd7, 1'b0, UP, WRAP, 1'b0);
        tick();
        exp_v = {4'd7, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pre_reset_load7: got %h exp %h", obs, exp_v); end
        // en high with count=7, then reset mid-cycle, well before the next edge
        set_in(1'b0, 4'd0, 1'b1, UP, WRAP, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL async_reset: got %h exp %h", obs, exp_v); end
        tick();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_held_edge: got %h exp %h", obs, exp_v); end
        // release between edges; the very next edge steps
        rst_n = 1'b1;
        tick();
        exp_v = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL first_step_after_release: got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_wrap_up();
        set_in(1'b1, 4'd0, 1'b0, UP, WRAP, 1'b0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            exp_q.push_back({4'(i % 10), (i == 10), (i == 10), 1'b0, (i == 10)});
        end
        set_in(1'b0, 4'd0, 1'b1, UP, WRAP, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL wrap_up step %0d: got %h exp %h", i, obs, exp_v); end
        end
        set_in(1'b0, 4'd0, 1'b0, UP, WRAP, 1'b0);
        tick();
        exp_v = {4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wrap_ovf_sticky: got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_sat_down();
        set_in(1'b1, 4'd1, 1'b0, UP, WRAP, 1'b0);
        tick();
        exp_q.push_back({4'd0, 1'b0, 1'b1, 1'b0, 1'b1});
        exp_q.push_back({4'd0, 1'b1, 1'b1, 1'b1, 1'b1});
        exp_q.push_back({4'd0, 1'b1, 1'b1, 1'b1, 1'b1});
        exp_q.push_back({4'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        set_in(1'b0, 4'd0, 1'b1, DOWN, SAT, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) set_in(1'b0, 4'd0, 1'b0, DOWN, SAT, 1'b0);
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL sat_down step %0d: got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_load();
        set_in(1'b1, 4'd13, 1'b0, UP, WRAP, 1'b0);
        tick();
        exp_v = {4'd9, 1'b0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL load_clamp13: got %h exp %h", obs, exp_v); end
        set_in(1'b1, 4'd4, 1'b0, UP, WRAP, 1'b0);
        tick();
        exp_v = {4'd4, 1'b0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL load4: got %h exp %h", obs, exp_v); end
        set_in(1'b1, 4'd10, 1'b0, UP, WRAP, 1'b0);
        tick();
        exp_v = {4'd9, 1'b0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL load_clamp10: got %h exp %h", obs, exp_v); end
        // load with en at the up boundary: load wins, no event
        set_in(1'b1, 4'd9, 1'b1, UP, WRAP, 1'b0);
        tick();
        exp_v = {4'd9, 1'b0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL load_over_en: got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_clr_flags();
        set_in(1'b0, 4'd0, 1'b0, UP, WRAP, 1'b1);
        tick();
        exp_v = {4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL clr_no_event: got %h exp %h", obs, exp_v); end
        set_in(1'b0, 4'd0, 1'b1, UP, WRAP, 1'b1);
        tick();
        exp_v = {4'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL clr_vs_wrap: got %h exp %h", obs, exp_v); end
        set_in(1'b0, 4'd0, 1'b1, DOWN, SAT, 1'b1);
        tick();
        exp_v = {4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL clr_vs_sat_down: got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_hold();
        set_in(1'b1, 4'd6, 1'b0, UP, WRAP, 1'b0);
        tick();
        exp_v = {4'd6, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 4'(i * 3), 1'b0, i[0], i[1], 1'b0);
            tick();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL hold %0d: got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_mode_switch();
        // load 0 and clear flags together: load sets no flag, clear applies
        set_in(1'b1, 4'd0, 1'b0, UP, WRAP, 1'b1);
        tick();
        exp_q.push_back({4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        exp_q.push_back({4'd9, 1'b1, 1'b0, 1'b1, 1'b0});
        exp_q.push_back({4'd0, 1'b1, 1'b1, 1'b1, 1'b1});
        exp_q.push_back({4'd1, 1'b0, 1'b1, 1'b1, 1'b0});
        exp_q.push_back({4'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        exp_q.push_back({4'd0, 1'b1, 1'b1, 1'b1, 1'b1});
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL load_clr: got %h exp %h", obs, exp_v); end
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       set_in(1'b0, 4'd0, 1'b1, DOWN, WRAP, 1'b0);
                1:       set_in(1'b0, 4'd0, 1'b1, UP,   WRAP, 1'b0);
                2:       set_in(1'b0, 4'd0, 1'b1, UP,   SAT,  1'b0);
                default: set_in(1'b0, 4'd0, 1'b1, DOWN, SAT,  1'b0);
            endcase
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL mode_switch %0d: got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_mod16();
        set_in(1'b0, 4'd0, 1'b0, UP, WRAP, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs16 !== exp_v) begin errors++; $display("FAIL m16_reset: got %h exp %h", obs16, exp_v); end
        rst_n = 1'b1;
        set_in(1'b1, 4'd15, 1'b0, UP, WRAP, 1'b0);
        tick();
        exp_v = {4'd15, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs16 !== exp_v) begin errors++; $display("FAIL m16_load15: got %h exp %h", obs16, exp_v); end
        exp_v = {4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL m10_load15_clamp: got %h exp %h", obs, exp_v); end
        exp_q.push_back({4'd0,  1'b1, 1'b1, 1'b0, 1'b1});
        exp_q.push_back({4'd15, 1'b1, 1'b1, 1'b1, 1'b0});
        exp_q.push_back({4'd14, 1'b0, 1'b1, 1'b1, 1'b0});
        exp_q.push_back({4'd14, 1'b0, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       set_in(1'b0, 4'd0, 1'b1, UP,   WRAP, 1'b0);
                1, 2:    set_in(1'b0, 4'd0, 1'b1, DOWN, WRAP, 1'b0);
                default: set_in(1'b0, 4'd0, 1'b0, UP,   WRAP, 1'b0);
            endcase
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs16 !== exp_v) begin errors++; $display("FAIL m16_step %0d: got %h exp %h", i, obs16, exp_v); end
        end
        // saturate at 15 going up
        set_in(1'b1, 4'd15, 1'b0, UP, SAT, 1'b0);
        tick();
        set_in(1'b0, 4'd0, 1'b1, UP, SAT, 1'b0);
        tick();
        exp_v = {4'd15, 1'b1, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs16 !== exp_v) begin errors++; $display("FAIL m16_sat_up: got %h exp %h", obs16, exp_v); end
        // zero follows count combinationally on an asynchronous reset
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (zero16 !== 1'b1) begin errors++; $display("FAIL m16_zero_async: got %b exp 1", zero16); end
        rst_n = 1'b1;
        set_in(1'b0, 4'd0, 1'b0, UP, WRAP, 1'b0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_async_reset();
        test_wrap_up();
        test_sat_down();
        test_load();
        test_clr_flags();
        test_hold();
        test_mode_switch();
        test_mod16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mod_updown_counter

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter N, default 8: counter width in bits.
REQ-002 Parameter MODULUS, default 2**N: count range 0..MODULUS-1; legal 2..2**N.
REQ-003 Parameter RST_VAL, default 0: reset value of count; legal 0..MODULUS-1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  count enable; count steps only when high.
REQ-007 up_down  input  1  direction: 0 = count up, 1 = count down.
REQ-008 sat  input  1  boundary mode: 0 = wrap modulo MODULUS, 1 = saturate at 0 / MODULUS-1.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  N  value captured on load.
REQ-011 clr_flags  input  1  synchronous clear of the sticky ovf/unf flags.
REQ-012 count  output  N  current count, registered.
REQ-013 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-014 ovf  output  1  sticky flag: an up-step was attempted at MODULUS-1.
REQ-015 unf  output  1  sticky flag: a down-step was attempted at 0.
REQ-016 zero  output  1  combinational; high when count == 0.

Function
REQ-017 Priority per edge: load > en > hold.
REQ-018 Load: count <= load_val when load_val < MODULUS, else count <= MODULUS-1; load never sets tc, ovf or unf.
REQ-019 Up-step (en=1, up_down=0, count < MODULUS-1): count <= count+1.
REQ-020 Down-step (en=1, up_down=1, count > 0): count <= count-1.
REQ-021 Up boundary (count == MODULUS-1, up-step): wrap mode -> count <= 0; sat mode -> count holds; in both modes tc=1 and ovf=1 on the next cycle.
REQ-022 Down boundary (count == 0, down-step): wrap mode -> count <= MODULUS-1; sat mode -> count holds; in both modes tc=1 and unf=1 on the next cycle.
REQ-023 tc is high for exactly one cycle per boundary event; back-to-back boundary events (saturated, en held high) keep tc high on every such cycle.
REQ-024 Boundary arithmetic is done in N+1 bits or by explicit compare; no implicit N-bit overflow is relied on, including when MODULUS == 2**N.
REQ-025 clr_flags clears ovf and unf on the next edge; a boundary event in the same cycle wins, so the corresponding flag is set.
REQ-026 load and en asserted together: load applies; no boundary event is recorded.
REQ-027 en=0 and load=0: count, ovf and unf hold; tc=0.
REQ-028 mode and direction are sampled per cycle; changing sat or up_down mid-count takes effect on the next enabled step.

Reset
REQ-029 rst_n low asynchronously forces count=RST_VAL, tc=0, ovf=0, unf=0, independent of clk.
REQ-030 Reset release is synchronous to clk: the first step occurs on the first rising edge with rst_n high.
REQ-031 Reset asserted mid-count discards the in-flight step; no flag survives reset.

Structure
REQ-032 Shared package mod_counter_pkg holds the direction encodings (DIR_UP=0, DIR_DOWN=1) and mode encodings (MODE_WRAP=0, MODE_SAT=1).
REQ-033 Parameter legality (MODULUS range, RST_VAL < MODULUS) is checked at elaboration with a fatal error.
REQ-034 Single flat module: one count register, one boundary-detect/next-state block and one flag register; no sub-module.

Verification (N=4, MODULUS=10, RST_VAL=0)
REQ-035 Reset during count=7 with en=1 -> count=0, tc=0, ovf=0, unf=0 immediately, before any clk edge.
REQ-036 Wrap mode, up, en=1 from 0 for 10 cycles -> count 1..9,0; tc high only in the cycle after 9->0; ovf=1 and stays set.
REQ-037 Sat mode, down, from count=1 for 3 cycles -> count 0,0,0; tc high on cycles 2 and 3; unf=1.
REQ-038 load=1, load_val=13 -> count=9; load=1 with en=1, up, load_val=9 -> count=9, tc=0, ovf unchanged.
REQ-039 ovf=1, clr_flags=1 with no event -> ovf=0 next cycle; clr_flags=1 together with a 9->0 wrap -> ovf stays 1.
REQ-040 MODULUS=16 build: up-wrap 15->0 and down-wrap 0->15 with tc pulses; zero tracks count==0 combinationally.
